// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operands and opcode in, registered result and flags out.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] num_1;
  logic [WIDTH-1:0] num_2;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             negative;

  // Issuer / writeback side.
  modport master (
    output in_valid, num_1, num_2, opcode, out_ready,
    input  in_ready, out_valid, result, zero, carry, overflow, negative
  );

  // ALU side.
  modport slave (
    input  in_valid, num_1, num_2, opcode, out_ready,
    output in_ready, out_valid, result, zero, carry, overflow, negative
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle arithmetic/logic ops, iterative variable shifts and
// shift-add multiply. One operation in flight; result held until the consumer takes it.
module alu_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpSub = 4'h1;
  localparam logic [3:0] OpAnd = 4'h2;
  localparam logic [3:0] OpOr  = 4'h3;
  localparam logic [3:0] OpXor = 4'h4;
  localparam logic [3:0] OpNot = 4'h5;
  localparam logic [3:0] OpShl = 4'h6;
  localparam logic [3:0] OpShr = 4'h7;
  localparam logic [3:0] OpMul = 4'h8;

  // count must hold WIDTH itself for the multiply, hence one extra bit.
  localparam logic [SHW:0] CntOne   = (SHW + 1)'(1);
  localparam logic [SHW:0] MulCount = (SHW + 1)'(WIDTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state;
  logic [3:0]           op;
  logic [SHW:0]         count;
  logic [WIDTH-1:0]     work;   // operand being shifted, or remaining multiplier bits
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic                 out_valid;
  logic [WIDTH-1:0]     result;
  logic                 zero;
  logic                 carry;
  logic                 overflow;
  logic                 negative;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [SHW-1:0]       amt;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic                 alu_v;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     step_res;
  logic                 step_c;

  assign bus.in_ready  = rst_n && (state == StIdle);
  assign bus.out_valid = out_valid;
  assign bus.result    = result;
  assign bus.zero      = zero;
  assign bus.carry     = carry;
  assign bus.overflow  = overflow;
  assign bus.negative  = negative;

  // Single-cycle result and flags straight from the request inputs.
  always_comb begin
    sum     = {1'b0, bus.num_1} + {1'b0, bus.num_2};
    diff    = {1'b0, bus.num_1} - {1'b0, bus.num_2};
    amt     = bus.num_2[SHW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.opcode)
      OpAdd: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.num_1[WIDTH-1] == bus.num_2[WIDTH-1]) &&
                  (sum[WIDTH-1] != bus.num_1[WIDTH-1]);
      end
      OpSub: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];  // borrow: zero-extended difference went negative
        alu_v   = (bus.num_1[WIDTH-1] != bus.num_2[WIDTH-1]) &&
                  (diff[WIDTH-1] != bus.num_1[WIDTH-1]);
      end
      OpAnd:        alu_res = bus.num_1 & bus.num_2;
      OpOr:         alu_res = bus.num_1 | bus.num_2;
      OpXor:        alu_res = bus.num_1 ^ bus.num_2;
      OpNot:        alu_res = ~bus.num_1;
      OpShl, OpShr: alu_res = bus.num_1;  // only reached here for a zero shift amount
      default:      alu_res = '0;
    endcase
  end

  // One iteration of the current multi-cycle op.
  always_comb begin
    acc_next = acc + (work[0] ? mcand : '0);
    step_res = '0;
    step_c   = 1'b0;
    if (op == OpMul) begin
      step_res = acc_next[WIDTH-1:0];
      step_c   = |acc_next[2*WIDTH-1:WIDTH];
    end else if (op == OpShl) begin
      step_res = {work[WIDTH-2:0], 1'b0};
      step_c   = work[WIDTH-1];
    end else begin
      step_res = {1'b0, work[WIDTH-1:1]};
      step_c   = work[0];
    end
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= StIdle;
      op        <= '0;
      count     <= '0;
      work      <= '0;
      mcand     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      negative  <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (bus.in_valid) begin
            op <= bus.opcode;
            if ((bus.opcode == OpShl || bus.opcode == OpShr) && amt != '0) begin
              count <= {1'b0, amt};
              work  <= bus.num_1;
              state <= StBusy;
            end else if (bus.opcode == OpMul) begin
              count <= MulCount;
              work  <= bus.num_2;
              mcand <= {{WIDTH{1'b0}}, bus.num_1};
              acc   <= '0;
              state <= StBusy;
            end else begin
              result    <= alu_res;
              carry     <= alu_c;
              overflow  <= alu_v;
              zero      <= (alu_res == '0);
              negative  <= alu_res[WIDTH-1];
              out_valid <= 1'b1;
              state     <= StDone;
            end
          end
        end
        StBusy: begin
          count <= count - CntOne;
          if (op == OpMul) begin
            acc   <= acc_next;
            mcand <= mcand << 1;
            work  <= work >> 1;
          end else begin
            work <= step_res;
          end
          if (count == CntOne) begin
            result    <= step_res;
            carry     <= step_c;
            overflow  <= 1'b0;
            zero      <= (step_res == '0);
            negative  <= step_res[WIDTH-1];
            out_valid <= 1'b1;
            state     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases, randomized ops against an arithmetic
// reference model, backpressure, throughput and reset in the middle of a multiply.
module tb_alu_seq;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // {result, zero, carry, overflow, negative}
  logic [19:0] outs;
  assign outs = {bus.result, bus.zero, bus.carry, bus.overflow, bus.negative};

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [19:0] exp;
    int          lat;
    string       name;
  } vec_t;

  // Reference: expected outputs and number of edges after acceptance until out_valid.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [19:0] exp, output int lat);
    int          s;
    int          sa;
    int          sb;
    int          k;
    longint      p;
    logic [15:0] r;
    logic        c;
    logic        v;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    k   = int'(b[3:0]);
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    lat = 0;
    case (op)
      4'h0: begin
        s = int'(a) + int'(b); r = s[15:0]; c = (s > 65535);
        s = sa + sb; v = (s > 32767) || (s < -32768);
      end
      4'h1: begin
        s = int'(a) - int'(b); r = s[15:0]; c = (a < b);
        s = sa - sb; v = (s > 32767) || (s < -32768);
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = ~a;
      4'h6: begin
        s = int'(a) << k; r = s[15:0];
        if (k > 0) c = s[16];
        lat = k;
      end
      4'h7: begin
        r = a >> k;
        if (k > 0) c = a[k-1];
        lat = k;
      end
      4'h8: begin
        p = longint'(a) * longint'(b); r = p[15:0]; c = (p[31:16] != 0); lat = 16;
      end
      default: r = '0;
    endcase
    exp = {r, (r == 16'h0), c, v, r[15]};
  endfunction

  // Issue one request, scramble inputs after acceptance, wait for the result.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input bit consume, output logic [19:0] got, output int lat);
    int n = 0;
    bus.opcode   = op;
    bus.num_1    = a;
    bus.num_2    = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.num_1    = 16'($urandom);
    bus.num_2    = 16'($urandom);
    bus.opcode   = 4'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus.out_valid) lat = -1;
    got = outs;
    if (consume) begin
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.num_1     = '0;
    bus.num_2     = '0;
    bus.opcode    = '0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, outs, bus.in_ready} !== 22'h0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", {bus.out_valid, outs, bus.in_ready}, 22'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_release got=%b exp=01", {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_directed();
    vec_t        v[8];
    logic [19:0] got;
    int          lat;
    v[0] = '{4'h0, 16'hFFFF, 16'h0001, {16'h0000, 4'b1100}, 0,  "add_wrap"};
    v[1] = '{4'h1, 16'h8000, 16'h0001, {16'h7FFF, 4'b0010}, 0,  "sub_ovf"};
    v[2] = '{4'h1, 16'h0001, 16'h0002, {16'hFFFF, 4'b0101}, 0,  "sub_borrow"};
    v[3] = '{4'h6, 16'h0001, 16'h000F, {16'h8000, 4'b0001}, 15, "shl_15"};
    v[4] = '{4'h7, 16'h0003, 16'h0001, {16'h0001, 4'b0100}, 1,  "shr_1"};
    v[5] = '{4'h6, 16'h1234, 16'h0030, {16'h1234, 4'b0000}, 0,  "shl_0"};
    v[6] = '{4'h8, 16'h0100, 16'h0100, {16'h0000, 4'b1100}, 16, "mul_hi"};
    v[7] = '{4'h8, 16'h0012, 16'h0034, {16'h03A8, 4'b0000}, 16, "mul_small"};
    for (int i = 0; i < 8; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, 1'b1, got, lat);
      checks++;
      if (got !== v[i].exp) begin
        errors++;
        $display("FAIL %s outputs got=%h exp=%h", v[i].name, got, v[i].exp);
      end
      checks++;
      if (lat !== v[i].lat) begin
        errors++;
        $display("FAIL %s latency got=%0d exp=%0d", v[i].name, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_random();
    logic [19:0] got;
    logic [19:0] exp;
    int          lat;
    int          elat;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      model(op, a, b, exp, elat);
      run_op(op, a, b, 1'b1, got, lat);
      checks++;
      if (got !== exp || lat !== elat) begin
        errors++;
        $display("FAIL rand op=%h a=%h b=%h got=%h/%0d exp=%h/%0d", op, a, b, got, lat, exp, elat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [19:0] got;
    logic [19:0] exp;
    int          lat;
    int          elat;
    logic [15:0] a;
    logic [15:0] b;
    a = 16'($urandom);
    b = 16'($urandom);
    model(4'h0, a, b, exp, elat);
    run_op(4'h0, a, b, 1'b0, got, lat);
    checks++;
    if (got !== exp || lat !== elat) begin
      errors++;
      $display("FAIL bp_first got=%h/%0d exp=%h/%0d", got, lat, exp, elat);
    end
    bus.opcode   = 4'h1;
    bus.num_1    = ~a;
    bus.num_2    = b ^ 16'h5A5A;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({outs, bus.out_valid, bus.in_ready} !== {exp, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got=%h exp=%h", i,
                 {outs, bus.out_valid, bus.in_ready}, {exp, 1'b1, 1'b0});
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release got=%b exp=01", {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_back_to_back();
    int highs = 0;
    bus.opcode    = 4'h2;
    bus.num_1     = 16'($urandom);
    bus.num_2     = 16'($urandom);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) highs++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (highs !== 10) begin
      errors++;
      $display("FAIL throughput got=%0d exp=10 results in 20 cycles", highs);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    logic [19:0] got;
    logic [19:0] exp;
    int          lat;
    int          elat;
    int          n = 0;
    bit          pulse = 1'b0;
    logic [15:0] a;
    logic [15:0] b;
    bus.opcode   = 4'h8;
    bus.num_1    = 16'h1234;
    bus.num_2    = 16'h5678;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, outs, bus.in_ready} !== 22'h0) begin
      errors++;
      $display("FAIL mid_reset_state got=%h exp=%h", {bus.out_valid, outs, bus.in_ready}, 22'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) pulse = 1'b1;
    end
    checks++;
    if (pulse !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_discard got=%b%b exp=01", pulse, bus.in_ready);
    end
    a = 16'($urandom);
    b = 16'($urandom);
    model(4'h0, a, b, exp, elat);
    run_op(4'h0, a, b, 1'b1, got, lat);
    checks++;
    if (got !== exp || lat !== elat) begin
      errors++;
      $display("FAIL post_reset_add got=%h/%0d exp=%h/%0d", got, lat, exp, elat);
    end
    run_op(4'hF, a, b, 1'b1, got, lat);
    checks++;
    if (got !== {16'h0000, 4'b1000} || lat !== 0) begin
      errors++;
      $display("FAIL illegal_op got=%h/%0d exp=%h/0", got, lat, {16'h0000, 4'b1000});
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
